// File: rtl/hs32_bus_arb.sv
// hs32 bus arbiter: N masters share one slave port. Each level request becomes
// a single-cycle slave strobe; the slave acknowledge (or a timeout) is returned
// to the granted master as a one-cycle m_ack pulse. All outputs are registered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate over m_stb, latch winner's rw/addr/dtw onto s_*
// ISSUE | s_stb high for this single cycle, timeout counter running
// WAIT  | s_stb low, s_* held, waiting for s_ack or timeout
// DONE  | m_ack pulse to the granted master, no arbitration
module hs32_bus_arb #(
   parameter int NM        = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NM-1:0]    m_stb,
   input  logic [NM-1:0]    m_rw,
   input  logic [NM-1:0]    m_lock,
   input  logic [NM*AW-1:0] m_addr,
   input  logic [NM*DW-1:0] m_dtw,
   output logic [NM-1:0]    m_ack,
   output logic             m_err,
   output logic [DW-1:0]    m_dtr,
   output logic             s_stb,
   output logic             s_rw,
   output logic [AW-1:0]    s_addr,
   output logic [DW-1:0]    s_dtw,
   input  logic             s_ack,
   input  logic [DW-1:0]    s_dtr,
   output logic [NM-1:0]    o_gnt,
   output logic             o_busy
);

   localparam int IW        = (NM > 1) ? $clog2(NM) : 1;
   localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
   localparam logic [IW-1:0] LAST_RST = IW'(NM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [NM-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]   last_q, last_d;
   logic            lock_q, lock_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NM-1:0]   ack_q, ack_d;
   logic            err_q, err_d;
   logic [DW-1:0]   dtr_q, dtr_d;
   logic            stb_q, stb_d;
   logic            rw_q, rw_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   dtw_q, dtw_d;
   logic            busy_q, busy_d;

   logic            lock_hold;
   logic            win_found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic [NM-1:0]   win_oh;
   logic            timeout_hit;

   // A held lock only survives while its owner keeps both lock and request up.
   assign lock_hold   = lock_q && m_lock[last_q] && m_stb[last_q];
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   // Winner selection: lock owner, else fixed priority or round-robin from last+1.
   // Loops run from lowest to highest priority so the final hit wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      if (lock_hold) begin
         win_found = 1'b1;
         win_idx   = last_q;
      end else if (PRIO_MODE != 0) begin
         for (int i = NM - 1; i >= 0; i--) begin
            if (m_stb[i]) begin
               win_found = 1'b1;
               win_idx   = IW'(i);
            end
         end
      end else begin
         for (int k = NM; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NM);
            if (m_stb[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // One-hot form of the winner for the grant register.
   always_comb begin
      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      err_d   = err_q;
      dtr_d   = dtr_q;
      stb_d   = 1'b0;
      rw_d    = rw_q;
      addr_d  = addr_q;
      dtw_d   = dtw_q;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            // the lock is consumed here; completion re-arms it if still wanted
            lock_d = 1'b0;
            if (win_found) begin
               state_d = ISSUE;
               gnt_d   = win_oh;
               last_d  = win_idx;
               cnt_d   = '0;
               stb_d   = 1'b1;
               busy_d  = 1'b1;
               rw_d    = m_rw[win_idx];
               addr_d  = m_addr[int'(win_idx)*AW +: AW];
               dtw_d   = m_dtw[int'(win_idx)*DW +: DW];
            end
         end
         ISSUE, WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (s_ack) begin
               state_d = DONE;
               ack_d   = gnt_q;
               err_d   = 1'b0;
               dtr_d   = s_dtr;
               busy_d  = 1'b0;
               lock_d  = m_lock[last_q];
            end else if (timeout_hit) begin
               state_d = DONE;
               ack_d   = gnt_q;
               err_d   = 1'b1;
               dtr_d   = '0;
               busy_d  = 1'b0;
               lock_d  = m_lock[last_q];
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= LAST_RST;
         lock_q  <= 1'b0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         dtr_q   <= '0;
         stb_q   <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         dtw_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dtr_q   <= dtr_d;
         stb_q   <= stb_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         dtw_q   <= dtw_d;
         busy_q  <= busy_d;
      end
   end

   assign m_ack  = ack_q;
   assign m_err  = err_q;
   assign m_dtr  = dtr_q;
   assign s_stb  = stb_q;
   assign s_rw   = rw_q;
   assign s_addr = addr_q;
   assign s_dtw  = dtw_q;
   assign o_gnt  = gnt_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_hs32_bus_arb.sv
// Directed bench for hs32_bus_arb: a 3-master round-robin instance with an
// 8-cycle timeout and a programmable slave, plus a 2-master fixed-priority
// instance with a zero-wait slave.
module tb_hs32_bus_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   // round-robin instance
   logic [2:0]  m_stb, m_rw, m_lock;
   logic [95:0] m_addr, m_dtw;
   logic [2:0]  m_ack;
   logic        m_err;
   logic [31:0] m_dtr;
   logic        s_stb, s_rw;
   logic [31:0] s_addr, s_dtw;
   logic        s_ack;
   logic [31:0] s_dtr;
   logic [2:0]  o_gnt;
   logic        o_busy;

   // fixed-priority instance
   logic [1:0]  f_m_stb, f_m_rw, f_m_lock;
   logic [63:0] f_m_addr, f_m_dtw;
   logic [1:0]  f_m_ack;
   logic        f_m_err;
   logic [31:0] f_m_dtr;
   logic        f_s_stb, f_s_rw;
   logic [31:0] f_s_addr, f_s_dtw;
   logic        f_s_ack;
   logic [31:0] f_s_dtr;
   logic [1:0]  f_o_gnt;
   logic        f_o_busy;

   // slave model for the round-robin instance
   int          slv_wait;
   logic        slv_silent;
   logic        force_ack;
   int          left;
   logic [31:0] rd_data;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                    left <= 0;
      else if (s_stb && !slv_silent && slv_wait > 0)   left <= slv_wait;
      else if (left > 0)                               left <= left - 1;
   end

   assign s_ack   = force_ack | (s_stb & ~slv_silent & (slv_wait == 0)) | (left == 1);
   assign s_dtr   = rd_data;
   assign f_s_ack = f_s_stb;
   assign f_s_dtr = 32'hCAFE_0001;

   hs32_bus_arb #(.NM(3), .AW(32), .DW(32), .PRIO_MODE(0), .TIMEOUT(8)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .m_stb(m_stb), .m_rw(m_rw), .m_lock(m_lock), .m_addr(m_addr), .m_dtw(m_dtw),
      .m_ack(m_ack), .m_err(m_err), .m_dtr(m_dtr),
      .s_stb(s_stb), .s_rw(s_rw), .s_addr(s_addr), .s_dtw(s_dtw),
      .s_ack(s_ack), .s_dtr(s_dtr), .o_gnt(o_gnt), .o_busy(o_busy)
   );

   hs32_bus_arb #(.NM(2), .AW(32), .DW(32), .PRIO_MODE(1), .TIMEOUT(0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .m_stb(f_m_stb), .m_rw(f_m_rw), .m_lock(f_m_lock), .m_addr(f_m_addr), .m_dtw(f_m_dtw),
      .m_ack(f_m_ack), .m_err(f_m_err), .m_dtr(f_m_dtr),
      .s_stb(f_s_stb), .s_rw(f_s_rw), .s_addr(f_s_addr), .s_dtw(f_s_dtw),
      .s_ack(f_s_ack), .s_dtr(f_s_dtr), .o_gnt(f_o_gnt), .o_busy(f_o_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for an ack; a timed-out wait returns ack=0.
   task automatic wait_ack(output logic [2:0] a, output int cyc);
      a   = '0;
      cyc = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cyc++;
         if (m_ack != 3'b000) begin
            a = m_ack;
            break;
         end
      end
   endtask

   task automatic wait_ack_f(output logic [1:0] a, output int cyc);
      a   = '0;
      cyc = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cyc++;
         if (f_m_ack != 2'b00) begin
            a = f_m_ack;
            break;
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      checks++;
      if ({m_ack, m_err, m_dtr, s_stb, s_rw, s_addr, s_dtw, o_gnt, o_busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b err=%b dtr=%h stb=%b rw=%b addr=%h dtw=%h gnt=%b busy=%b, expected all 0",
                  m_ack, m_err, m_dtr, s_stb, s_rw, s_addr, s_dtw, o_gnt, o_busy);
      end
      checks++;
      if ({f_m_ack, f_s_stb, f_o_gnt, f_o_busy} !== '0) begin
         errors++;
         $display("FAIL reset_fp_outputs: got ack=%b stb=%b gnt=%b busy=%b, expected 0", f_m_ack, f_s_stb, f_o_gnt, f_o_busy);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      m_addr[31:0] = 32'h0000_0040;
      m_rw         = 3'b000;
      rd_data      = 32'h1234_5678;
      m_stb        = 3'b001;
      tick();
      checks++;
      if ({s_stb, s_rw, s_addr} !== {1'b1, 1'b0, 32'h40}) begin
         errors++;
         $display("FAIL single_issue: got stb=%b rw=%b addr=%h, expected stb=1 rw=0 addr=00000040", s_stb, s_rw, s_addr);
      end
      checks++;
      if ({o_gnt, o_busy, m_ack} !== {3'b001, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL single_grant: got gnt=%b busy=%b ack=%b, expected gnt=001 busy=1 ack=000", o_gnt, o_busy, m_ack);
      end
      tick();
      checks++;
      if ({m_ack, m_err, m_dtr} !== {3'b001, 1'b0, 32'h1234_5678}) begin
         errors++;
         $display("FAIL single_ack: got ack=%b err=%b dtr=%h, expected ack=001 err=0 dtr=12345678", m_ack, m_err, m_dtr);
      end
      checks++;
      if ({s_stb, o_busy} !== 2'b00) begin
         errors++;
         $display("FAIL single_stb_pulse: got stb=%b busy=%b, expected 0 0", s_stb, o_busy);
      end
      m_stb = 3'b000;
      tick();
      checks++;
      if ({m_ack, o_gnt} !== 6'b0) begin
         errors++;
         $display("FAIL single_idle: got ack=%b gnt=%b, expected 000 000", m_ack, o_gnt);
      end
   endtask

   task automatic test_wait_states();
      logic [2:0] a;
      int         cyc;
      slv_wait     = 2;
      m_addr[31:0] = 32'h0000_0044;
      rd_data      = 32'hDEAD_BEEF;
      m_stb        = 3'b001;
      tick();
      wait_ack(a, cyc);
      checks++;
      if (a !== 3'b001 || cyc !== 3) begin
         errors++;
         $display("FAIL wait2_latency: got ack=%b after %0d cycles, expected ack=001 after 3", a, cyc);
      end
      checks++;
      if ({m_err, m_dtr} !== {1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL wait2_data: got err=%b dtr=%h, expected err=0 dtr=deadbeef", m_err, m_dtr);
      end
      m_stb    = 3'b000;
      tick();
      slv_wait = 0;
   endtask

   task automatic test_round_robin();
      logic [2:0] a;
      int         cyc;
      do_reset();
      m_addr  = {32'h300, 32'h200, 32'h100};
      rd_data = 32'h0BAD_F00D;
      m_stb   = 3'b111;
      for (int i = 0; i < 6; i++) begin
         wait_ack(a, cyc);
         checks++;
         if (a !== (3'b001 << (i % 3))) begin
            errors++;
            $display("FAIL rr_order[%0d]: got ack=%b, expected %b", i, a, 3'b001 << (i % 3));
         end
         checks++;
         if (o_gnt !== a) begin
            errors++;
            $display("FAIL rr_gnt_match[%0d]: got gnt=%b, expected %b", i, o_gnt, a);
         end
         checks++;
         if (cyc !== ((i == 0) ? 2 : 3)) begin
            errors++;
            $display("FAIL rr_spacing[%0d]: got %0d cycles, expected %0d", i, cyc, (i == 0) ? 2 : 3);
         end
         checks++;
         if (s_addr !== 32'h100 * (i % 3 + 1)) begin
            errors++;
            $display("FAIL rr_addr[%0d]: got %h, expected %h", i, s_addr, 32'h100 * (i % 3 + 1));
         end
      end
      m_stb = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_fixed_priority();
      logic [1:0] a;
      int         cyc;
      f_m_stb = 2'b11;
      for (int i = 0; i < 3; i++) begin
         wait_ack_f(a, cyc);
         checks++;
         if (a !== 2'b01 || f_o_gnt !== 2'b01) begin
            errors++;
            $display("FAIL fp_master0[%0d]: got ack=%b gnt=%b, expected 01 01", i, a, f_o_gnt);
         end
         checks++;
         if (cyc !== ((i == 0) ? 2 : 3)) begin
            errors++;
            $display("FAIL fp_spacing[%0d]: got %0d cycles, expected %0d", i, cyc, (i == 0) ? 2 : 3);
         end
      end
      f_m_stb = 2'b10;
      wait_ack_f(a, cyc);
      checks++;
      if (a !== 2'b10 || f_m_dtr !== 32'hCAFE_0001 || f_m_err !== 1'b0) begin
         errors++;
         $display("FAIL fp_master1: got ack=%b dtr=%h err=%b, expected 10 cafe0001 0", a, f_m_dtr, f_m_err);
      end
      f_m_stb = 2'b00;
      tick();
      tick();
   endtask

   task automatic test_lock();
      logic [2:0] a;
      int         cyc;
      do_reset();
      m_addr         = {32'h300, 32'h110, 32'h010};
      m_dtw[63:32]   = 32'hA5A5_0001;
      m_rw           = 3'b010;
      m_lock         = 3'b010;
      m_stb          = 3'b010;
      tick();
      checks++;
      if ({o_gnt, s_rw, s_dtw} !== {3'b010, 1'b1, 32'hA5A5_0001}) begin
         errors++;
         $display("FAIL lock_first_grant: got gnt=%b rw=%b dtw=%h, expected 010 1 a5a50001", o_gnt, s_rw, s_dtw);
      end
      m_stb = 3'b011;
      for (int i = 0; i < 3; i++) begin
         wait_ack(a, cyc);
         checks++;
         if (a !== 3'b010) begin
            errors++;
            $display("FAIL lock_hold[%0d]: got ack=%b, expected 010", i, a);
         end
      end
      m_lock = 3'b000;
      wait_ack(a, cyc);
      checks++;
      if (a !== 3'b001) begin
         errors++;
         $display("FAIL lock_release: got ack=%b, expected 001", a);
      end
      m_stb = 3'b000;
      m_rw  = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      int cyc;
      slv_silent     = 1'b1;
      m_addr[95:64]  = 32'h0000_02C0;
      rd_data        = 32'h5555_AAAA;
      m_stb          = 3'b100;
      tick();
      checks++;
      if (s_stb !== 1'b1) begin
         errors++;
         $display("FAIL to_issue: got stb=%b, expected 1", s_stb);
      end
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cyc++;
         if (cyc == 4) begin
            checks++;
            if ({o_busy, s_stb, s_addr} !== {1'b1, 1'b0, 32'h2C0}) begin
               errors++;
               $display("FAIL to_wait_stable: got busy=%b stb=%b addr=%h, expected 1 0 000002c0", o_busy, s_stb, s_addr);
            end
         end
         if (m_ack != 3'b000) break;
      end
      checks++;
      if (cyc !== 8 || m_ack !== 3'b100) begin
         errors++;
         $display("FAIL to_latency: got ack=%b after %0d cycles, expected 100 after 8", m_ack, cyc);
      end
      checks++;
      if ({m_err, m_dtr} !== {1'b1, 32'h0}) begin
         errors++;
         $display("FAIL to_err: got err=%b dtr=%h, expected 1 00000000", m_err, m_dtr);
      end
      m_stb = 3'b000;
      tick();
      force_ack = 1'b1;
      tick();
      tick();
      checks++;
      if ({m_ack, o_gnt, o_busy} !== 7'b0) begin
         errors++;
         $display("FAIL to_late_ack: got ack=%b gnt=%b busy=%b, expected 000 000 0", m_ack, o_gnt, o_busy);
      end
      force_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      logic [2:0] a;
      int         cyc;
      m_addr[31:0] = 32'h0000_0080;
      m_stb        = 3'b001;
      tick();
      tick();
      tick();
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_wait: got busy=%b, expected 1", o_busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({m_ack, m_err, m_dtr, s_stb, s_rw, s_addr, s_dtw, o_gnt, o_busy} !== '0) begin
         errors++;
         $display("FAIL rst_async: got ack=%b err=%b dtr=%h stb=%b addr=%h gnt=%b busy=%b, expected all 0",
                  m_ack, m_err, m_dtr, s_stb, s_addr, o_gnt, o_busy);
      end
      slv_silent = 1'b0;
      rd_data    = 32'h0000_00AB;
      tick();
      tick();
      checks++;
      if (m_ack !== 3'b000) begin
         errors++;
         $display("FAIL rst_no_ack: got ack=%b, expected 000", m_ack);
      end
      reset_n = 1'b1;
      wait_ack(a, cyc);
      checks++;
      if (a !== 3'b001 || cyc !== 2 || m_dtr !== 32'h0000_00AB) begin
         errors++;
         $display("FAIL rst_regrant: got ack=%b cyc=%0d dtr=%h, expected 001 2 000000ab", a, cyc, m_dtr);
      end
      m_stb = 3'b000;
      tick();
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      m_stb      = '0;
      m_rw       = '0;
      m_lock     = '0;
      m_addr     = '0;
      m_dtw      = '0;
      f_m_stb    = '0;
      f_m_rw     = '0;
      f_m_lock   = '0;
      f_m_addr   = {32'h0000_0200, 32'h0000_0100};
      f_m_dtw    = '0;
      slv_wait   = 0;
      slv_silent = 1'b0;
      force_ack  = 1'b0;
      rd_data    = '0;

      test_reset();
      test_single_read();
      test_wait_states();
      test_round_robin();
      test_fixed_priority();
      test_lock();
      test_timeout();
      test_reset_in_wait();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hs32_bus_arb.md
# hs32_bus_arb

Parametrised N-master arbiter for the hs32 memory bus. It replaces the fixed two-way `bus_hold` multiplexer between the Caravel Wishbone port and the CPU with a registered arbiter that serves any number of masters. It converts each master's level request into a single-cycle slave strobe and returns the slave acknowledge to the granted master. It sits between the masters (CPU, Caravel Wishbone bridge, future DMA) and the MMIO interconnect / SRAM controller. It adds round-robin or fixed-priority selection, bus locking and a slave-timeout error.

## Interface
Parameters:
- `NM`, 2, number of masters (1..8)
- `AW`, 32, address width
- `DW`, 32, data width
- `PRIO_MODE`, 0, 0 = round-robin, 1 = fixed priority (master 0 highest)
- `TIMEOUT`, 255, cycles to wait for `s_ack` before an error completion; 0 disables the timeout

Ports:
- `clk`  in  1  bus clock
- `reset_n`  in  1  asynchronous, active-low reset
- `m_stb`  in  NM  per-master request, level; held until that master's `m_ack`
- `m_rw`  in  NM  per-master direction, 1 = write
- `m_lock`  in  NM  per-master lock request
- `m_addr`  in  NM*AW  flattened addresses, master i at `[i*AW +: AW]`
- `m_dtw`  in  NM*DW  flattened write data
- `m_ack`  out  NM  one-hot completion pulse
- `m_err`  out  1  valid with `m_ack`; 1 = timeout
- `m_dtr`  out  DW  read data broadcast to all masters, valid with `m_ack`
- `s_stb`  out  1  single-cycle slave strobe
- `s_rw`  out  1  slave direction
- `s_addr`  out  AW  slave address
- `s_dtw`  out  DW  slave write data
- `s_ack`  in  1  slave acknowledge
- `s_dtr`  in  DW  slave read data
- `o_gnt`  out  NM  one-hot current grant, 0 when idle
- `o_busy`  out  1  high in ISSUE or WAIT

## Operation
- FSM states and transitions:
  - IDLE: arbitrate over `m_stb`. If any request is present, register the winner into `o_gnt` and register its `rw`, `addr` and `dtw` onto the `s_*` outputs, then go to ISSUE.
  - ISSUE: `s_stb`=1 for exactly one cycle. If `s_ack` is high in this cycle, complete; otherwise go to WAIT.
  - WAIT: `s_stb`=0. `s_*` outputs stay stable. Complete on `s_ack` or on timeout.
  - DONE: `m_ack[g]`=1 for one cycle, then go to IDLE. No arbitration happens in DONE.
- Completion on `s_ack`: latch `s_dtr` into `m_dtr` and set `m_err`=0.
- Completion on timeout: set `m_dtr`=0 and `m_err`=1.
- Round-robin arbitration:
  - A pointer `last` holds the most recent grant.
  - The search starts at `last+1` and wraps modulo NM; the first requesting master wins.
  - `last` is updated on every grant.
- Fixed-priority arbitration: the lowest requesting index wins.
- Lock: if `m_lock[g]` is high at completion, the arbiter stays locked to g.
  - In the next IDLE, only `m_stb[g]` is considered.
  - The lock is released when IDLE samples `m_lock[g]`=0, or when g makes no request in that IDLE cycle.
- Timeout counter:
  - Cleared on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - Fires when count == TIMEOUT-1 with no `s_ack`.
  - Counter width is clog2(TIMEOUT+1).
  - With TIMEOUT=0, WAIT never times out.
- `s_ack` is ignored in IDLE and DONE; a late ack after a timeout is dropped.
- If a master drops `m_stb` while granted, the transaction still completes and the `m_ack` pulse is still issued.
- A master must not change `m_rw`, `m_addr` or `m_dtw` while `m_stb` is high. The arbiter samples these only at grant.

## Timing
- Reset (asynchronous assert; release synchronous to `clk`):
  - State = IDLE.
  - All outputs 0: `m_ack`, `m_err`, `m_dtr`, `s_stb`, `s_rw`, `s_addr`, `s_dtw`, `o_gnt`, `o_busy`.
  - `last` = NM-1, so master 0 wins the first round-robin arbitration.
  - The lock is cleared.
- Reset asserted mid-transaction aborts it immediately; no `m_ack` is issued.
- All outputs are registered.
- Zero-wait slave (ack during the `s_stb` cycle):
  - Request sampled at edge E0.
  - `s_stb` high during E0–E1.
  - `m_ack` high during E1–E2.
  - Next arbitration at E3.
  - Back-to-back throughput is 1 transaction per 3 cycles.
- Slave with k wait cycles: `m_ack` rises k cycles later than for a zero-wait slave.
- Timeout: `m_ack` with `m_err`=1 rises TIMEOUT cycles after `s_stb` rises.
- Masters deassert or renew `m_stb` at the edge ending their `m_ack` cycle. DONE guarantees a stale `m_stb` is not re-sampled.

## Test plan
- Single master 0 reads 0x0000_0040 with a zero-wait slave returning 0x1234_5678 -> one `s_stb` pulse with `s_addr`=0x40, `s_rw`=0; `m_ack`=0b01 exactly one cycle later with `m_dtr`=0x1234_5678 and `m_err`=0.
- Round-robin (NM=3): all three masters request continuously -> grant order 0,1,2,0,1,2; each `m_ack` is one-hot and matches `o_gnt`.
- PRIO_MODE=1: masters 0 and 1 both request, and master 0 re-requests immediately after each ack -> master 1 is never granted while master 0 requests; master 1 is granted when master 0 idles.
- Lock: master 1 writes with `m_lock`=1 for 3 transactions while master 0 requests -> three consecutive grants to master 1, then master 0 is granted after the lock drops.
- Timeout with TIMEOUT=8 and a silent slave -> `m_ack` with `m_err`=1 and `m_dtr`=0 eight cycles after `s_stb`; a subsequent late `s_ack` produces no `m_ack`.
- `reset_n` pulsed low in WAIT -> all outputs are 0 asynchronously; no `m_ack` is issued; the next request is granted normally from IDLE.
